// File: rtl/wb_master_pkg.sv
// Shared types and constants for the wb_master Wishbone initiator.
package wb_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StBus,
        StHold,
        StFin
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam int unsigned ADDR_INC = 4;

endpackage

// File: rtl/wb_master.sv
// Wishbone B4 classic/registered-feedback initiator: single accesses and incrementing bursts.
// Defining WB_MASTER_TIMEOUT_EN adds a stalled-strobe abort after TIMEOUT_CYCLES.
module wb_master
    import wb_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = 26,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_BEATS      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned SEL_W         = DATA_W / 8,
    localparam int unsigned LEN_W         = $clog2(MAX_BEATS)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [LEN_W-1:0]  cmd_len,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,

    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,

    output logic              done,
    output logic              err,

    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] dat_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic [2:0]        cti_o,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] dat_i
);

    state_e r_state;
    state_e w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_dat;
    logic [DATA_W-1:0] r_rd_data;
    logic [LEN_W-1:0]  r_beats;
    logic              r_we;
    logic              r_single;
    logic              r_open;

    logic w_accept;
    logic w_ack;
    logic w_last;
    logic w_abort;

    assign w_accept = (r_state == StIdle) && cmd_valid;
    assign w_ack    = (r_state == StBus) && ack_i;
    // r_beats counts beats remaining after the current one
    assign w_last   = (r_beats == '0);

    assign we_o    = r_we;
    assign addr_o  = r_addr;
    assign sel_o   = r_sel;
    assign dat_o   = r_dat;
    assign rd_data = r_rd_data;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_state != StBus || ack_i) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Abort on the last permitted stalled cycle so stb_o is high exactly TIMEOUT_CYCLES cycles
    assign w_abort = (r_state == StBus) && !ack_i && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end
    end

    assign err = (r_state == StFin) && r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_abort          = 1'b0;
    assign err              = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        rd_valid     = 1'b0;
        done         = 1'b0;
        cyc_o        = 1'b0;
        stb_o        = 1'b0;
        cti_o        = CTI_CLASSIC;
        unique case (r_state)
            StIdle: begin
                cmd_ready = reset;
                if (cmd_valid) begin
                    w_state_next = cmd_we ? StFetch : StBus;
                end
            end
            StFetch: begin
                wr_ready = 1'b1;
                cyc_o    = r_open;
                if (wr_valid) begin
                    w_state_next = StBus;
                end
            end
            StBus: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                if (!r_single) begin
                    cti_o = w_last ? CTI_END : CTI_INCR;
                end
                if (w_abort) begin
                    w_state_next = StFin;
                end else if (ack_i) begin
                    if (r_we) begin
                        w_state_next = w_last ? StFin : StFetch;
                    end else begin
                        w_state_next = StHold;
                    end
                end
            end
            StHold: begin
                cyc_o    = 1'b1;
                rd_valid = 1'b1;
                if (rd_ready) begin
                    w_state_next = w_last ? StFin : StBus;
                end
            end
            StFin: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_sel     <= '0;
            r_beats   <= '0;
            r_single  <= 1'b0;
            r_dat     <= '0;
            r_rd_data <= '0;
            r_open    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= cmd_we;
                r_addr   <= cmd_addr;
                r_sel    <= cmd_sel;
                r_beats  <= cmd_len;
                r_single <= (cmd_len == '0);
            end
            if (r_state == StFetch && wr_valid) begin
                r_dat <= wr_data;
            end
            if (w_ack) begin
                r_addr <= r_addr + ADDR_W'(ADDR_INC);
                if (r_we) begin
                    if (!w_last) begin
                        r_beats <= r_beats - 1'b1;
                    end
                end else begin
                    r_rd_data <= dat_i;
                end
            end
            // Reads retire a beat only once the consumer has taken the data
            if (r_state == StHold && rd_ready && !w_last) begin
                r_beats <= r_beats - 1'b1;
            end
            if (r_state == StBus) begin
                r_open <= 1'b1;
            end else if (r_state == StFin) begin
                r_open <= 1'b0;
            end
        end
    end

endmodule
